// File: rtl/ad9833_pkg.sv
// Shared types, control-word constants and helpers for the AD9833 sequencer.
// Build option: define AD9833_PHASE_EN to make PSELECT follow FSELECT in every control word.
package ad9833_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE        = 2'd0,
    WAVE_TRIANGLE    = 2'd1,
    WAVE_SQUARE      = 2'd2,
    WAVE_SQUARE_DIV2 = 2'd3
  } wave_e;

  typedef enum logic [2:0] {
    INIT_ISSUE = 3'd0,
    INIT_WAIT  = 3'd1,
    IDLE       = 3'd2,
    A_ISSUE    = 3'd3,
    A_WAIT     = 3'd4,
    B_ISSUE    = 3'd5,
    B_WAIT     = 3'd6,
    GAP        = 3'd7
  } state_e;

  localparam logic [15:0] CTRL_B28     = 16'h2000;
  localparam logic [15:0] CTRL_FSELECT = 16'h0800;
  localparam logic [15:0] CTRL_PSELECT = 16'h0400;
  localparam logic [15:0] CTRL_RESET   = 16'h0100;
  localparam logic [15:0] CTRL_OPBITEN = 16'h0020;
  localparam logic [15:0] CTRL_DIV2    = 16'h0008;
  localparam logic [15:0] CTRL_MODE    = 16'h0002;

  localparam logic [1:0] PFX_FREQ0 = 2'b01;
  localparam logic [1:0] PFX_FREQ1 = 2'b10;
  localparam logic [1:0] PFX_PHASE = 2'b11;

  localparam logic [15:0] INIT_CONTROL = CTRL_B28 | CTRL_RESET;
  localparam logic [15:0] INIT_ADREG   = {PFX_FREQ0, 14'h0000};

  function automatic logic [15:0] wave_bits(input wave_e wave);
    case (wave)
      WAVE_SINE:        wave_bits = 16'h0000;
      WAVE_TRIANGLE:    wave_bits = CTRL_MODE;
      WAVE_SQUARE:      wave_bits = CTRL_OPBITEN | CTRL_DIV2;
      WAVE_SQUARE_DIV2: wave_bits = CTRL_OPBITEN;
      default:          wave_bits = 16'h0000;
    endcase
  endfunction

  // Control word with RESET clear, selecting register bank sel.
  function automatic logic [15:0] control_word(input logic sel, input wave_e wave);
    logic [15:0] bank;
`ifdef AD9833_PHASE_EN
    bank = sel ? (CTRL_FSELECT | CTRL_PSELECT) : 16'h0000;
`else
    bank = sel ? CTRL_FSELECT : 16'h0000;
`endif
    control_word = CTRL_B28 | bank | wave_bits(wave);
  endfunction

endpackage

// File: rtl/ad9833_txn.sv
// One driver transaction: hold go until latched, wait for the fsync low/high frame,
// then optionally count an idle gap before reporting done.
module ad9833_txn
  import ad9833_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic use_gap,
  input  logic good,
  input  logic fsync,
  output logic go,
  output logic acked,
  output logic frame_done,
  output logic done
);

  localparam int CNT_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_ISSUE = 2'd1,
    T_WAIT  = 2'd2,
    T_GAP   = 2'd3
  } txn_state_e;

  txn_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             seen_low, seen_low_next;
  logic             go_next;

  // Engine state, gap counter, fsync-low tracker and registered go.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= T_ISSUE;
      cnt      <= '0;
      seen_low <= 1'b0;
      go       <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      seen_low <= seen_low_next;
      go       <= go_next;
    end
  end

  // Next state; a low fsync sampled together with the ack already counts as seen.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    seen_low_next = seen_low;
    go_next       = 1'b0;
    acked         = 1'b0;
    frame_done    = 1'b0;
    done          = 1'b0;
    case (state)
      T_IDLE: begin
        if (start) begin
          state_next = T_ISSUE;
          go_next    = 1'b1;
        end else begin
          state_next = T_IDLE;
        end
      end
      T_ISSUE: begin
        if (go && good) begin
          acked         = 1'b1;
          state_next    = T_WAIT;
          seen_low_next = ~fsync;
        end else begin
          go_next = 1'b1;
        end
      end
      T_WAIT: begin
        if (!seen_low) begin
          seen_low_next = ~fsync;
        end else if (fsync) begin
          frame_done = 1'b1;
          if (use_gap) begin
            state_next = T_GAP;
            cnt_next   = CNT_W'(GAP_CYCLES);
          end else begin
            done       = 1'b1;
            state_next = T_IDLE;
          end
        end else begin
          seen_low_next = 1'b1;
        end
      end
      T_GAP: begin
        if (cnt == '0) begin
          done = 1'b1;
          if (start) begin
            state_next = T_ISSUE;
            go_next    = 1'b1;
          end else begin
            state_next = T_IDLE;
          end
        end else begin
          cnt_next = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_next = T_IDLE;
    endcase
  end

endmodule

// File: rtl/ad9833_ctrl.sv
// AD9833 sequencer: init transaction after reset, then ping-pong FREQ0/FREQ1 updates
// as an A/B transaction pair per request. Build option: AD9833_PHASE_EN writes the phase word.
module ad9833_ctrl
  import ad9833_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [27:0] req_freq,
  input  logic [11:0] req_phase,
  input  logic [1:0]  req_wave,
  output logic        busy,
  output logic        active_sel,
  output logic        drv_go,
  output logic [15:0] drv_control,
  output logic [15:0] drv_adreg0,
  output logic [15:0] drv_adreg1,
  input  logic        drv_good_to_reset_go,
  input  logic        drv_fsync
);

  state_e      state, state_next;
  logic        gap_to_b;
  logic [27:0] freq;
  wave_e       wave;
  logic        start, use_gap, acked, frame_done, done;
  logic [1:0]  freq_pfx;
  logic [15:0] ctl_next, a0_next, a1_next;

`ifdef AD9833_PHASE_EN
  logic [11:0] phase;
`else
  logic        unused_phase;
  assign unused_phase = ^req_phase;
`endif

  assign use_gap  = (state != INIT_WAIT);
  assign freq_pfx = active_sel ? PFX_FREQ0 : PFX_FREQ1;

  ad9833_txn #(.GAP_CYCLES(GAP_CYCLES)) u_txn (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .use_gap    (use_gap),
    .good       (drv_good_to_reset_go),
    .fsync      (drv_fsync),
    .go         (drv_go),
    .acked      (acked),
    .frame_done (frame_done),
    .done       (done)
  );

  // Sequencer next state; start marks entry into an A or B issue.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      INIT_ISSUE: state_next = acked ? INIT_WAIT : INIT_ISSUE;
      INIT_WAIT:  state_next = done ? IDLE : INIT_WAIT;
      IDLE: begin
        if (req_valid) begin
          state_next = A_ISSUE;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      A_ISSUE:    state_next = acked ? A_WAIT : A_ISSUE;
      A_WAIT:     state_next = frame_done ? GAP : A_WAIT;
      B_ISSUE:    state_next = acked ? B_WAIT : B_ISSUE;
      B_WAIT:     state_next = frame_done ? GAP : B_WAIT;
      GAP: begin
        if (done && gap_to_b) begin
          state_next = B_ISSUE;
          start      = 1'b1;
        end else if (done) begin
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
      default:    state_next = INIT_ISSUE;
    endcase
  end

  // Words for the next issue: txn A straight from the request, txn B from latched fields.
  always_comb begin
    ctl_next = drv_control;
    a0_next  = drv_adreg0;
    a1_next  = drv_adreg1;
    if (state == IDLE) begin
      ctl_next = control_word(active_sel, wave_e'(req_wave));
      a0_next  = {freq_pfx, req_freq[13:0]};
      a1_next  = {freq_pfx, req_freq[27:14]};
    end else begin
      ctl_next = control_word(active_sel, wave);
`ifdef AD9833_PHASE_EN
      a0_next  = {PFX_PHASE, ~active_sel, 1'b0, phase};
`else
      a0_next  = control_word(active_sel, wave);
`endif
      a1_next  = control_word(~active_sel, wave);
    end
  end

  // Registered state, status flags, request latch and driver words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT_ISSUE;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
      active_sel  <= 1'b0;
      gap_to_b    <= 1'b0;
      freq        <= 28'h0000000;
      wave        <= WAVE_SINE;
      drv_control <= INIT_CONTROL;
      drv_adreg0  <= INIT_ADREG;
      drv_adreg1  <= INIT_ADREG;
`ifdef AD9833_PHASE_EN
      phase       <= 12'h000;
`endif
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      if (state == IDLE && req_valid) begin
        freq  <= req_freq;
        wave  <= wave_e'(req_wave);
`ifdef AD9833_PHASE_EN
        phase <= req_phase;
`endif
      end
      if (frame_done && state == A_WAIT) begin
        gap_to_b <= 1'b1;
      end else if (frame_done && state == B_WAIT) begin
        gap_to_b   <= 1'b0;
        active_sel <= ~active_sel;
      end
      if (start) begin
        drv_control <= ctl_next;
        drv_adreg0  <= a0_next;
        drv_adreg1  <= a1_next;
      end
    end
  end

endmodule

// File: tb/tb_ad9833_ctrl.sv
// Randomized self-checking bench for ad9833_ctrl with a behavioural AD9833 driver model.
module tb_ad9833_ctrl;

  localparam int GAP = 4;
`ifdef AD9833_PHASE_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  typedef struct {
    logic [47:0] w;
    int          gap;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [27:0] req_freq = 28'h0;
  logic [11:0] req_phase = 12'h0;
  logic [1:0]  req_wave = 2'd0;
  logic        busy, active_sel, drv_go;
  logic [15:0] drv_control, drv_adreg0, drv_adreg1;
  logic        drv_good_to_reset_go;
  logic        drv_fsync;

  int   vectors = 0;
  int   miscompares = 0;
  txn_t txq[$];
  bit   fixed_timing = 1'b1;
  bit   model_sel = 1'b0;

  ad9833_ctrl #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_freq(req_freq), .req_phase(req_phase), .req_wave(req_wave),
    .busy(busy), .active_sel(active_sel), .drv_go(drv_go),
    .drv_control(drv_control), .drv_adreg0(drv_adreg0), .drv_adreg1(drv_adreg1),
    .drv_good_to_reset_go(drv_good_to_reset_go), .drv_fsync(drv_fsync)
  );

  always #5 clk = ~clk;

  // Reference control word: B28, bank bits for x, waveform bits.
  function automatic logic [15:0] m_cw(input bit x, input logic [1:0] w);
    logic [15:0] wt [4];
    wt = '{16'h0000, 16'h0002, 16'h0028, 16'h0020};
    m_cw = 16'h2000 + (x ? 16'h0800 : 16'h0000) + ((PHASE_EN && x) ? 16'h0400 : 16'h0000) + wt[w];
  endfunction

  function automatic logic [47:0] exp_a(input bit s, input logic [27:0] f, input logic [1:0] w);
    logic [15:0] pre;
    pre = s ? 16'h4000 : 16'h8000;
    exp_a = {m_cw(s, w), pre + 16'(f % 28'd16384), pre + 16'(f / 28'd16384)};
  endfunction

  function automatic logic [47:0] exp_b(input bit s, input logic [11:0] p, input logic [1:0] w);
    logic [15:0] a0;
    a0 = PHASE_EN ? (16'hC000 + (s ? 16'h0000 : 16'h2000) + 16'(p)) : m_cw(s, w);
    exp_b = {m_cw(s, w), a0, m_cw(!s, w)};
  endfunction

  // Driver model: latch after a delay, shift a frame with fsync low, record every transaction.
  initial begin : drv_model
    int   gap, dly, len;
    bit   same, rst_seen;
    txn_t t;
    drv_good_to_reset_go = 1'b0;
    drv_fsync = 1'b1;
    gap = 0;
    forever begin
      @(negedge clk);
      if (drv_go === 1'b1 && rst === 1'b0) begin
        t.w = {drv_control, drv_adreg0, drv_adreg1};
        t.gap = gap;
        txq.push_back(t);
        rst_seen = 1'b0;
        dly  = fixed_timing ? 3 : int'($urandom_range(1, 5));
        len  = fixed_timing ? 6 : int'($urandom_range(1, 8));
        same = fixed_timing ? 1'b0 : ($urandom_range(0, 1) == 1);
        repeat (dly) begin @(negedge clk); rst_seen = rst_seen | (rst === 1'b1); end
        drv_good_to_reset_go = 1'b1;
        if (same) drv_fsync = 1'b0;
        @(negedge clk);
        rst_seen = rst_seen | (rst === 1'b1);
        if (!rst_seen) begin
          vectors++;
          if (drv_go !== 1'b0) begin miscompares++; $display("FAIL go_fall: drv_go=%b, want 0", drv_go); end
        end
        drv_good_to_reset_go = 1'b0;
        drv_fsync = 1'b0;
        repeat (same ? len - 1 : len) begin @(negedge clk); rst_seen = rst_seen | (rst === 1'b1); end
        if (!rst_seen) begin
          vectors++;
          if ({drv_control, drv_adreg0, drv_adreg1} !== t.w) begin
            miscompares++;
            $display("FAIL words_stable: got %h, want %h", {drv_control, drv_adreg0, drv_adreg1}, t.w);
          end
        end
        drv_fsync = 1'b1;
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && i < 600) begin @(negedge clk); i++; end
    if (req_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: req_ready=%b, want 1 within 600 cycles", name, req_ready);
    end
  endtask

  task automatic run_request(input string name, input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    logic [47:0] ea, eb;
    txn_t ta, tb;
    wait_idle(name);
    ea = exp_a(model_sel, f, w);
    eb = exp_b(model_sel, p, w);
    txq.delete();
    req_freq = f; req_phase = p; req_wave = w; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if ({drv_go, drv_control, drv_adreg0, drv_adreg1} !== {1'b1, ea}) begin
      miscompares++;
      $display("FAIL %s_latency: got go=%b %h, want go=1 %h", name, drv_go, {drv_control, drv_adreg0, drv_adreg1}, ea);
    end
    wait_idle(name);
    vectors++;
    if (txq.size() != 2) begin
      miscompares++; $display("FAIL %s_count: got %0d txns, want 2", name, txq.size());
    end else begin
      ta = txq.pop_front();
      tb = txq.pop_front();
      vectors++;
      if (ta.w !== ea) begin miscompares++; $display("FAIL %s_txn_a: got %h, want %h", name, ta.w, ea); end
      vectors++;
      if (tb.w !== eb) begin miscompares++; $display("FAIL %s_txn_b: got %h, want %h", name, tb.w, eb); end
      vectors++;
      if (tb.gap != GAP + 1) begin miscompares++; $display("FAIL %s_gap: got %0d, want %0d", name, tb.gap, GAP + 1); end
    end
    model_sel = !model_sel;
    vectors++;
    if (active_sel !== model_sel) begin miscompares++; $display("FAIL %s_sel: got %b, want %b", name, active_sel, model_sel); end
  endtask

  task automatic test_reset;
    fixed_timing = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({drv_go, req_ready, busy, active_sel} !== 4'b0010) begin
      miscompares++; $display("FAIL reset_flags: go/ready/busy/sel=%b, want 0010", {drv_go, req_ready, busy, active_sel});
    end
    vectors++;
    if ({drv_control, drv_adreg0, drv_adreg1} !== 48'h2100_4000_4000) begin
      miscompares++; $display("FAIL reset_words: got %h, want 210040004000", {drv_control, drv_adreg0, drv_adreg1});
    end
    txq.delete();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (drv_go !== 1'b1) begin miscompares++; $display("FAIL reset_go_rise: drv_go=%b, want 1", drv_go); end
    wait_idle("init");
    vectors++;
    if (txq.size() != 1 || txq[0].w !== 48'h2100_4000_4000) begin
      miscompares++; $display("FAIL init_txn: got %0d txns, first %h, want 1 x 210040004000", txq.size(), (txq.size() > 0) ? txq[0].w : 48'h0);
    end
    vectors++;
    if ({active_sel, busy} !== 2'b00) begin miscompares++; $display("FAIL init_idle: sel/busy=%b, want 00", {active_sel, busy}); end
    model_sel = 1'b0;
  endtask

  task automatic test_directed;
    fixed_timing = 1'b1;
    run_request("req1", 28'h0ABCDEF, 12'h123, 2'd0);
    run_request("req2", 28'h0000001, 12'h000, 2'd1);
  endtask

  task automatic test_random;
    fixed_timing = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run_request("rand", 28'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back;
    logic [27:0] f1, f2;
    logic [11:0] p1, p2;
    logic [1:0]  w1, w2;
    logic [47:0] e [4];
    int acc;
    f1 = 28'($urandom); f2 = 28'($urandom);
    p1 = 12'($urandom); p2 = 12'($urandom);
    w1 = 2'($urandom_range(0, 3)); w2 = 2'($urandom_range(0, 3));
    fixed_timing = 1'b0;
    wait_idle("b2b");
    txq.delete();
    e[0] = exp_a(model_sel, f1, w1);  e[1] = exp_b(model_sel, p1, w1);
    e[2] = exp_a(!model_sel, f2, w2); e[3] = exp_b(!model_sel, p2, w2);
    req_freq = f1; req_phase = p1; req_wave = w1; req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 1000 && req_valid; i++) begin
      if (req_ready === 1'b1) acc++;
      @(negedge clk);
      if (acc == 1) begin
        req_freq = f2; req_phase = p2; req_wave = w2;
      end else if (acc >= 2) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    wait_idle("b2b");
    repeat (10) @(negedge clk);
    vectors++;
    if (acc != 2) begin miscompares++; $display("FAIL b2b_accepts: got %0d, want 2", acc); end
    vectors++;
    if (txq.size() != 4) begin
      miscompares++; $display("FAIL b2b_count: got %0d txns, want 4", txq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (txq[k].w !== e[k]) begin miscompares++; $display("FAIL b2b_txn%0d: got %h, want %h", k, txq[k].w, e[k]); end
      end
    end
    vectors++;
    if (active_sel !== model_sel) begin miscompares++; $display("FAIL b2b_sel: got %b, want %b", active_sel, model_sel); end
  endtask

  task automatic test_reset_mid;
    int i;
    fixed_timing = 1'b1;
    wait_idle("rst_mid");
    txq.delete();
    req_freq = 28'($urandom); req_phase = 12'($urandom); req_wave = 2'($urandom_range(0, 3));
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    i = 0;
    while (drv_fsync !== 1'b0 && i < 100) begin @(negedge clk); i++; end
    vectors++;
    if (drv_fsync !== 1'b0) begin miscompares++; $display("FAIL rst_mid_frame: fsync=%b, want 0 within 100 cycles", drv_fsync); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({drv_go, active_sel, busy, req_ready} !== 4'b0010) begin
      miscompares++; $display("FAIL rst_mid_flags: go/sel/busy/ready=%b, want 0010", {drv_go, active_sel, busy, req_ready});
    end
    vectors++;
    if ({drv_control, drv_adreg0, drv_adreg1} !== 48'h2100_4000_4000) begin
      miscompares++; $display("FAIL rst_mid_words: got %h, want 210040004000", {drv_control, drv_adreg0, drv_adreg1});
    end
    @(negedge clk);
    txq.delete();
    rst = 1'b0;
    wait_idle("rst_mid_init");
    vectors++;
    if (txq.size() != 1 || txq[0].w !== 48'h2100_4000_4000) begin
      miscompares++; $display("FAIL rst_mid_init: got %0d txns, first %h, want 1 x 210040004000", txq.size(), (txq.size() > 0) ? txq[0].w : 48'h0);
    end
    model_sel = 1'b0;
    vectors++;
    if (active_sel !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sel: got %b, want 0", active_sel); end
  endtask

  task automatic test_after_reset;
    fixed_timing = 1'b1;
    run_request("post_rst", 28'($urandom), 12'($urandom), 2'($urandom_range(0, 3)));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_after_reset();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
